ghostbus_host: RTL and testbench

//   Bus initiator for the ghostbus: turns a valid/ready command stream into
//   gb_addr/gb_wdata/gb_wen/gb_rstb cycles and captures gb_rdata into a

---
 rtl/ghostbus_host.sv | 187 ++++++++++++++++++
 tb/tb_ghostbus_host.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghostbus_host.sv
`timescale 1ns/1ps
// ghostbus_host
//   Bus initiator for the ghostbus. Accepts one command at a time from a
//   valid/ready command stream and turns it into ghostbus cycles:
//     write : a single gb_wen pulse. The write is posted and produces no response.
//     read  : a burst of cmd_len+1 beats. Each beat is one gb_rstb pulse,
//             followed by a wait of RD cycles. gb_rdata is then captured into
//             the rsp_* stream, which is held until the consumer takes it.
//   The burst address auto-increments and wraps modulo 2^AW.
//
// Parameters
//   AW  address width          DW  data width
//   LW  burst length width     RD  read latency in cycles (>= 1)
//
// Ports
//   gb_clk, gb_rst_n         clock, synchronous active-low reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_we                   1 = write, 0 = read burst
//   cmd_addr                 start address
//   cmd_wdata                write data
//   cmd_len                  read beats minus one
//   rsp_valid/rsp_ready      read-beat handshake
//   rsp_rdata                captured read data
//   rsp_last                 marks the final beat of a burst
//   gb_addr, gb_wdata        bus address / write data (hold between strobes)
//   gb_wen, gb_rstb          one-cycle write / read strobes
//   gb_rdata                 bus read data
//   busy                     high whenever the FSM is not idle
module ghostbus_host #(
    parameter int AW = 24,
    parameter int DW = 32,
    parameter int LW = 8,
    parameter int RD = 8
) (
    input  logic          gb_clk,
    input  logic          gb_rst_n,

    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    input  logic [LW-1:0] cmd_len,

    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_last,

    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_wdata,
    output logic          gb_wen,
    output logic          gb_rstb,
    input  logic [DW-1:0] gb_rdata,

    output logic          busy
);

    // The delay counter must be able to hold RD itself.
    localparam int CW = $clog2(RD + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WSTB  = 3'd1;
    localparam logic [2:0] S_RSTB  = 3'd2;
    localparam logic [2:0] S_RWAIT = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]    state;
    logic [LW-1:0] remaining;   // beats still to issue after the current one
    logic [CW-1:0] delay_cnt;   // cycles left until gb_rdata is valid
    logic          cmd_fire;
    logic          rsp_fire;
    logic          data_due;

    // cmd_ready and busy are decodes of the state register only, so there
    // is no combinational path from any input to them.
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    assign cmd_fire  = cmd_valid & cmd_ready;
    assign rsp_fire  = rsp_valid & rsp_ready;

    // The count reaches 1 on the edge that is RD cycles after the edge
    // which saw gb_rstb high. That edge is the one where gb_rdata is sampled.
    assign data_due  = (delay_cnt == CW'(1));

    // ---------------------------------------------------------------------
    // Control: state, beat bookkeeping and the strobes.
    // ---------------------------------------------------------------------
    always_ff @(posedge gb_clk) begin
        if (!gb_rst_n) begin
            state     <= S_IDLE;
            remaining <= '0;
            delay_cnt <= '0;
            gb_wen    <= 1'b0;
            gb_rstb   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses. They are raised only on the
            // edge that enters WSTB or RSTB, and they fall on the next edge.
            gb_wen  <= 1'b0;
            gb_rstb <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (cmd_fire) begin
                        if (cmd_we) begin
                            gb_wen <= 1'b1;
                            state  <= S_WSTB;
                        end else begin
                            remaining <= cmd_len;
                            gb_rstb   <= 1'b1;
                            state     <= S_RSTB;
                        end
                    end
                end

                S_WSTB: begin
                    state <= S_IDLE;
                end

                S_RSTB: begin
                    delay_cnt <= CW'(RD);
                    state     <= S_RWAIT;
                end

                S_RWAIT: begin
                    delay_cnt <= delay_cnt - CW'(1);
                    if (data_due) begin
                        rsp_valid <= 1'b1;
                        rsp_last  <= (remaining == '0);
                        state     <= S_RESP;
                    end
                end

                S_RESP: begin
                    if (rsp_fire) begin
                        rsp_valid <= 1'b0;
                        rsp_last  <= 1'b0;
                        if (rsp_last) begin
                            state <= S_IDLE;
                        end else begin
                            remaining <= remaining - LW'(1);
                            gb_rstb   <= 1'b1;
                            state     <= S_RSTB;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Datapath: bus address/data and captured read data.
    // These registers hold their value between strobes, so the bus lines
    // do not toggle while nothing is happening.
    // ---------------------------------------------------------------------
    always_ff @(posedge gb_clk) begin
        if (!gb_rst_n) begin
            gb_addr   <= '0;
            gb_wdata  <= '0;
            rsp_rdata <= '0;
        end else begin
            if (cmd_fire) begin
                gb_addr <= cmd_addr;
                if (cmd_we) begin
                    gb_wdata <= cmd_wdata;
                end
            end

            if ((state == S_RWAIT) && data_due) begin
                rsp_rdata <= gb_rdata;
            end

            // The next beat address wraps modulo 2^AW through natural overflow.
            if ((state == S_RESP) && rsp_fire && !rsp_last) begin
                gb_addr <= gb_addr + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ghostbus_host.sv
`timescale 1ns/1ps
module tb_ghostbus_host;
    localparam int AW = 24;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int RD = 8;

    logic          gb_clk = 1'b0;
    logic          gb_rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [LW-1:0] cmd_len;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_last;
    logic [AW-1:0] gb_addr;
    logic [DW-1:0] gb_wdata;
    logic          gb_wen;
    logic          gb_rstb;
    logic [DW-1:0] gb_rdata;
    logic          busy;

    always #5 gb_clk = ~gb_clk;

    ghostbus_host #(.AW(AW), .DW(DW), .LW(LW), .RD(RD)) dut (
        .gb_clk    (gb_clk),
        .gb_rst_n  (gb_rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_len   (cmd_len),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_last  (rsp_last),
        .gb_addr   (gb_addr),
        .gb_wdata  (gb_wdata),
        .gb_wen    (gb_wen),
        .gb_rstb   (gb_rstb),
        .gb_rdata  (gb_rdata),
        .busy      (busy)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int viol     = 0;

    always @(posedge gb_clk) cyc <= cyc + 1;

    // Slave model: the data word for an address is the address XOR a pattern.
    function automatic logic [DW-1:0] model_data(input logic [AW-1:0] a);
        return DW'(a) ^ 32'hA5A5A5A5;
    endfunction

    // Bus model: data for a read strobe becomes valid exactly RD edges later.
    // Outside that one-cycle window the bus shows a junk word.
    logic          bv [RD];
    logic [AW-1:0] ba [RD];
    always @(posedge gb_clk) begin
        bv[0] <= gb_rstb;
        ba[0] <= gb_addr;
        for (int i = 1; i < RD; i++) begin
            bv[i] <= bv[i-1];
            ba[i] <= ba[i-1];
        end
    end
    assign gb_rdata = (bv[RD-1] === 1'b1) ? model_data(ba[RD-1]) : 32'h0BAD_F00D;

    // Observation logs filled at the falling edge
    logic [AW-1:0] wen_addr_q [$];
    logic [DW-1:0] wen_data_q [$];
    logic [AW-1:0] rstb_addr_q [$];
    int            rstb_cyc_q [$];
    logic [DW-1:0] rsp_data_q [$];
    logic          rsp_last_q [$];

    logic          prev_hold = 1'b0;
    logic          prev_wen  = 1'b0;
    logic          prev_rstb = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    always @(negedge gb_clk) begin : monitor
        int v;
        v = 0;
        if (gb_rst_n === 1'b1) begin
            if (gb_wen) begin
                wen_addr_q.push_back(gb_addr);
                wen_data_q.push_back(gb_wdata);
            end
            if (gb_rstb) begin
                rstb_addr_q.push_back(gb_addr);
                rstb_cyc_q.push_back(cyc);
            end
            if (gb_wen && gb_rstb) v++;
            if ((gb_wen || gb_rstb) && !busy) v++;
            if ((gb_wen && prev_wen) || (gb_rstb && prev_rstb)) v++;
            if (prev_hold && (!rsp_valid || rsp_rdata !== prev_data || rsp_last !== prev_last)) v++;
            if (rsp_valid && rsp_ready) begin
                rsp_data_q.push_back(rsp_rdata);
                rsp_last_q.push_back(rsp_last);
            end
            prev_hold <= rsp_valid && !rsp_ready;
            prev_data <= rsp_rdata;
            prev_last <= rsp_last;
            prev_wen  <= gb_wen;
            prev_rstb <= gb_rstb;
        end else begin
            prev_hold <= 1'b0;
            prev_wen  <= 1'b0;
            prev_rstb <= 1'b0;
        end
        viol <= viol + v;
    end

    task automatic tick();
        @(posedge gb_clk);
        #1;
    endtask

    // Present a command and hold it until it is accepted. The task returns
    // one time step after the accepting edge.
    task automatic send_cmd(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [LW-1:0] len, output int waited);
        bit ok;
        bit acc;
        ok = 0;
        waited = 0;
        cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_len = len; cmd_valid = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            acc = cmd_ready;
            tick();
            if (acc) ok = 1;
            else waited++;
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL cmd_accept_timeout got=not_accepted exp=accepted");
        end
    endtask

    // Drive rsp_ready until the response log reaches n entries.
    // mode 0: ready held high; mode 1: random ready.
    task automatic wait_beats(input int n, input int mode, input int budget);
        int t;
        t = 0;
        while (rsp_data_q.size() < n && t < budget) begin
            rsp_ready = (mode == 0) ? 1'b1 : 1'($urandom % 2);
            tick();
            t++;
        end
        rsp_ready = 1'b0;
        if (rsp_data_q.size() < n) begin
            checks++; failures++;
            $display("FAIL beat_timeout got=%0d exp=%0d", rsp_data_q.size(), n);
        end
    endtask

    task automatic test_reset();
        gb_rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({cmd_ready, rsp_valid, rsp_last, gb_wen, gb_rstb, busy} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=100000", {cmd_ready, rsp_valid, rsp_last, gb_wen, gb_rstb, busy});
        end
        checks++;
        if (rsp_rdata !== '0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
        checks++;
        if (gb_addr !== '0) begin failures++; $display("FAIL reset_gb_addr got=%h exp=0", gb_addr); end
        checks++;
        if (gb_wdata !== '0) begin failures++; $display("FAIL reset_gb_wdata got=%h exp=0", gb_wdata); end
        gb_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        int w, bw;
        logic cr_a, cr_b;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bw = wen_addr_q.size();
        send_cmd(1'b1, 24'h000010, 32'hDEADBEEF, '0, w);
        cr_a = cmd_ready;
        tick();
        cr_b = cmd_ready;
        checks++;
        if (cr_a !== 1'b0 || cr_b !== 1'b1) begin
            failures++; $display("FAIL write_cmd_ready got=%b%b exp=01", cr_a, cr_b);
        end
        checks++;
        if (wen_addr_q.size() != bw + 1) begin
            failures++; $display("FAIL write_pulse_count got=%0d exp=1", wen_addr_q.size() - bw);
        end else begin
            checks++;
            if (wen_addr_q[bw] !== 24'h000010 || wen_data_q[bw] !== 32'hDEADBEEF) begin
                failures++; $display("FAIL write_bus got=%h/%h exp=000010/deadbeef", wen_addr_q[bw], wen_data_q[bw]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            a = AW'($urandom); d = $urandom;
            bw = wen_addr_q.size();
            send_cmd(1'b1, a, d, LW'($urandom), w);
            tick();
            checks++;
            if (wen_addr_q.size() != bw + 1 || wen_addr_q[bw] !== a || wen_data_q[bw] !== d) begin
                failures++; $display("FAIL write_random got=%h/%h exp=%h/%h", gb_addr, gb_wdata, a, d);
            end
        end
    endtask

    task automatic test_read_single();
        int w, br, bs;
        br = rsp_data_q.size(); bs = rstb_addr_q.size();
        send_cmd(1'b0, 24'h000020, $urandom, '0, w);
        wait_beats(br + 1, 0, RD + 20);
        repeat (RD + 4) tick();
        checks++;
        if (rstb_addr_q.size() != bs + 1 || rstb_addr_q[bs] !== 24'h000020) begin
            failures++; $display("FAIL read1_strobe got=%0d exp=1", rstb_addr_q.size() - bs);
        end
        checks++;
        if (rsp_data_q.size() != br + 1 || rsp_data_q[br] !== 32'hA5A5A585 || rsp_last_q[br] !== 1'b1) begin
            failures++; $display("FAIL read1_beat got=%h exp=a5a5a585", rsp_rdata);
        end
    endtask

    task automatic test_read_wrap();
        int w, br, bs, errs;
        logic [AW-1:0] a, ea;
        a = 24'hFFFFFE;
        br = rsp_data_q.size(); bs = rstb_addr_q.size();
        send_cmd(1'b0, a, '0, 8'd3, w);
        wait_beats(br + 4, 0, 4 * (RD + 2) + 20);
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            ea = AW'(a + i);
            if (rstb_addr_q.size() <= bs + i || rstb_addr_q[bs+i] !== ea) errs++;
            if (rsp_data_q.size() <= br + i || rsp_data_q[br+i] !== model_data(ea)
                || rsp_last_q[br+i] !== (i == 3)) errs++;
            if (i > 0 && rstb_cyc_q.size() > bs + i && rstb_cyc_q[bs+i] - rstb_cyc_q[bs+i-1] != RD + 2) errs++;
        end
        checks++;
        if (errs != 0) begin failures++; $display("FAIL read_wrap got=%0d_errors exp=0", errs); end
        checks++;
        if (rstb_addr_q.size() > bs + 2 && rstb_addr_q[bs+2] !== 24'h000000) begin
            failures++; $display("FAIL read_wrap_zero got=%h exp=000000", rstb_addr_q[bs+2]);
        end
    endtask

    task automatic test_backpressure();
        int w, br, bs, t;
        logic [AW-1:0] a;
        logic [DW-1:0] d0;
        logic l0, stable;
        a = AW'($urandom);
        br = rsp_data_q.size(); bs = rstb_addr_q.size();
        rsp_ready = 1'b0;
        send_cmd(1'b0, a, '0, 8'd1, w);
        t = 0;
        while (rsp_valid !== 1'b1 && t < RD + 10) begin tick(); t++; end
        checks++;
        if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_first_valid got=0 exp=1"); end
        d0 = rsp_rdata; l0 = rsp_last; stable = 1'b1;
        repeat (20) begin
            tick();
            if (!(rsp_valid === 1'b1 && rsp_rdata === d0 && rsp_last === l0)) stable = 1'b0;
        end
        checks++;
        if (!stable) begin failures++; $display("FAIL bp_hold got=%b/%h exp=1/%h", rsp_valid, rsp_rdata, d0); end
        checks++;
        if (d0 !== model_data(a) || l0 !== 1'b0) begin
            failures++; $display("FAIL bp_beat0 got=%h/%b exp=%h/0", d0, l0, model_data(a));
        end
        checks++;
        if (rstb_addr_q.size() != bs + 1) begin
            failures++; $display("FAIL bp_no_second_strobe got=%0d exp=1", rstb_addr_q.size() - bs);
        end
        wait_beats(br + 2, 0, 2 * (RD + 2) + 20);
        checks++;
        if (rsp_data_q.size() != br + 2 || rsp_data_q[br+1] !== model_data(AW'(a + 1)) || rsp_last_q[br+1] !== 1'b1
            || rstb_addr_q.size() != bs + 2) begin
            failures++; $display("FAIL bp_beat1 got=%0d_beats exp=2", rsp_data_q.size() - br);
        end
    endtask

    task automatic test_reset_mid();
        int w, br, bs, bw;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        br = rsp_data_q.size(); bs = rstb_addr_q.size();
        send_cmd(1'b0, AW'($urandom), '0, 8'd3, w);
        repeat (3) tick();
        gb_rst_n = 1'b0;
        tick();
        checks++;
        if ({cmd_ready, rsp_valid, rsp_last, gb_wen, gb_rstb, busy} !== 6'b100000) begin
            failures++;
            $display("FAIL midreset_ctrl got=%b exp=100000", {cmd_ready, rsp_valid, rsp_last, gb_wen, gb_rstb, busy});
        end
        checks++;
        if (rsp_rdata !== '0 || gb_addr !== '0 || gb_wdata !== '0) begin
            failures++; $display("FAIL midreset_data got=%h/%h/%h exp=0/0/0", rsp_rdata, gb_addr, gb_wdata);
        end
        gb_rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (RD + 6) tick();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_data_q.size() != br || rstb_addr_q.size() != bs + 1) begin
            failures++; $display("FAIL midreset_abandon got=%0d_beats exp=0", rsp_data_q.size() - br);
        end
        a = AW'($urandom); d = $urandom;
        bw = wen_addr_q.size();
        send_cmd(1'b1, a, d, '0, w);
        tick();
        checks++;
        if (wen_addr_q.size() != bw + 1 || wen_addr_q[bw] !== a || wen_data_q[bw] !== d) begin
            failures++; $display("FAIL midreset_write got=%h/%h exp=%h/%h", gb_addr, gb_wdata, a, d);
        end
    endtask

    task automatic test_back_to_back();
        int w1, w2, br, bw, v0;
        logic [AW-1:0] a;
        v0 = viol;
        a = AW'($urandom);
        br = rsp_data_q.size(); bw = wen_addr_q.size();
        send_cmd(1'b1, AW'($urandom), $urandom, '0, w1);
        send_cmd(1'b0, a, '0, '0, w2);
        checks++;
        if (w2 != 1) begin failures++; $display("FAIL b2b_wait got=%0d exp=1", w2); end
        wait_beats(br + 1, 0, RD + 20);
        checks++;
        if (rsp_data_q.size() != br + 1 || rsp_data_q[br] !== model_data(a) || wen_addr_q.size() != bw + 1) begin
            failures++; $display("FAIL b2b_result got=%0d_beats exp=1", rsp_data_q.size() - br);
        end
        checks++;
        if (viol != v0) begin failures++; $display("FAIL b2b_strobes got=%0d exp=0", viol - v0); end
    endtask

    task automatic test_max_len();
        int w, br, bs, errs, nlast;
        logic [AW-1:0] a;
        a = AW'($urandom);
        br = rsp_data_q.size(); bs = rstb_addr_q.size();
        send_cmd(1'b0, a, '0, 8'hFF, w);
        wait_beats(br + 256, 0, 256 * (RD + 2) + 50);
        errs = 0; nlast = 0;
        for (int i = 0; i < 256 && br + i < rsp_data_q.size(); i++) begin
            if (rsp_data_q[br+i] !== model_data(AW'(a + i))) errs++;
            if (rsp_last_q[br+i]) nlast++;
            if (rsp_last_q[br+i] !== (i == 255)) errs++;
        end
        checks++;
        if (rsp_data_q.size() != br + 256 || errs != 0 || nlast != 1) begin
            failures++; $display("FAIL max_len got=%0d_beats/%0d_errors exp=256/0", rsp_data_q.size() - br, errs);
        end
        checks++;
        if (rstb_addr_q.size() != bs + 256) begin
            failures++; $display("FAIL max_len_strobes got=%0d exp=256", rstb_addr_q.size() - bs);
        end
    endtask

    task automatic test_random();
        int w, br, bs, bw, errs;
        logic we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [LW-1:0] len;
        for (int k = 0; k < 25; k++) begin
            we  = 1'($urandom % 2);
            a   = ($urandom % 4 == 0) ? AW'(24'hFFFFFF - ($urandom % 3)) : AW'($urandom);
            d   = $urandom;
            len = LW'($urandom % 4);
            br = rsp_data_q.size(); bs = rstb_addr_q.size(); bw = wen_addr_q.size();
            send_cmd(we, a, d, len, w);
            errs = 0;
            if (we) begin
                tick();
                if (wen_addr_q.size() != bw + 1 || wen_addr_q[bw] !== a || wen_data_q[bw] !== d) errs++;
                if (rstb_addr_q.size() != bs) errs++;
            end else begin
                wait_beats(br + int'(len) + 1, 1, (int'(len) + 1) * (RD + 40) + 20);
                for (int i = 0; i <= int'(len); i++) begin
                    if (rsp_data_q.size() <= br + i) errs++;
                    else if (rsp_data_q[br+i] !== model_data(AW'(a + i)) || rsp_last_q[br+i] !== (i == int'(len))) errs++;
                    if (rstb_addr_q.size() <= bs + i || rstb_addr_q[bs+i] !== AW'(a + i)) errs++;
                end
                if (rstb_addr_q.size() != bs + int'(len) + 1) errs++;
            end
            checks++;
            if (errs != 0) begin
                failures++; $display("FAIL random_cmd%0d we=%b got=%0d_errors exp=0", k, we, errs);
            end
        end
    endtask

    task automatic test_protocol();
        tick();
        checks++;
        if (viol != 0) begin failures++; $display("FAIL protocol_violations got=%0d exp=0", viol); end
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL final_idle got=%b%b exp=10", cmd_ready, busy);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        gb_rst_n  = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_len   = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_write();
        test_read_single();
        test_read_wrap();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_max_len();
        test_random();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
